// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: scoreboard, stall/flush sequencing, EX forwarding
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic             id_valid,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_REDIR} state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
  } slot_t;

  state_e           state_q, state_d;
  slot_t            ex_q, mem_q, wb_q;
  slot_t            id_slot;
  logic [1:0]       fwd_rs1_q, fwd_rs1_d, fwd_rs2_q, fwd_rs2_d;
  logic [CNT_W-1:0] cnt_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic       use_rs1, use_rs2, id_wr, id_load, id_csr;
  logic       load_use, slots_busy;
  logic       unused_bits;

  assign opcode      = id_inst[6:0];
  assign rd          = id_inst[11:7];
  assign funct3      = id_inst[14:12];
  assign rs1         = id_inst[19:15];
  assign rs2         = id_inst[24:20];
  assign unused_bits = ^{id_inst[31:25], wb_q[5:0], mem_q.is_load};

  // A slot entry only matters for hazards if it is real and writes a nonzero rd.
  function automatic logic hit(input slot_t s, input logic used, input logic [4:0] rs);
    return used && s.valid && s.wr && (s.rd == rs);
  endfunction

  // Decode register usage of the ID instruction; bubbles use and write nothing.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    id_wr   = 1'b0;
    id_load = id_valid && (opcode == OPC_LOAD);
    id_csr  = id_valid && (opcode == OPC_SYSTEM) && (funct3 != 3'd0);
    if (id_valid) begin
      case (opcode)
        OPC_OP:                    begin use_rs1 = 1'b1; use_rs2 = 1'b1; id_wr = 1'b1; end
        OPC_OP_IMM, OPC_LOAD:      begin use_rs1 = 1'b1; id_wr = 1'b1; end
        OPC_STORE, OPC_BRANCH:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OPC_JAL, OPC_LUI, OPC_AUIPC: id_wr = 1'b1;
        OPC_JALR:                  begin use_rs1 = 1'b1; id_wr = 1'b1; end
        OPC_SYSTEM: begin
          // CSRRW/S/C read rs1; the immediate forms (funct3[2]=1) do not.
          id_wr   = id_csr;
          use_rs1 = id_csr && !funct3[2];
        end
        default: ;
      endcase
    end
    if (rd == 5'd0) id_wr = 1'b0;
    id_slot.valid   = id_valid;
    id_slot.rd      = rd;
    id_slot.wr      = id_wr;
    id_slot.is_load = id_load;
  end

  assign load_use   = ex_q.is_load && (hit(ex_q, use_rs1, rs1) || hit(ex_q, use_rs2, rs2));
  assign slots_busy = ex_q.valid || mem_q.valid || wb_q.valid;

  // Prioritised pipeline control and next-state selection.
  always_comb begin
    state_d     = state_q;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    bubble_ex   = 1'b0;
    freeze      = 1'b0;
    if (rst) begin
      flush_if_id = 1'b1;
      bubble_ex   = 1'b1;
      state_d     = S_RUN;
    end else if (mem_busy) begin
      freeze      = 1'b1;
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
    end else if (ex_redirect) begin
      flush_if_id = 1'b1;
      bubble_ex   = 1'b1;
      state_d     = S_REDIR;
    end else begin
      case (state_q)
        S_REDIR: begin
          // Second wrong-path slot: the fetch issued in the redirect cycle.
          flush_if_id = 1'b1;
          state_d     = S_RUN;
        end
        S_DRAIN: begin
          if (slots_busy) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
        default: begin
          if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
          end else if (id_csr && slots_busy) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
            state_d     = S_DRAIN;
          end
        end
      endcase
    end
  end

  // Forwarding select for the instruction about to enter EX; EX slot is the newer producer.
  always_comb begin
    fwd_rs1_d = 2'd0;
    fwd_rs2_d = 2'd0;
    if (!bubble_ex) begin
      if (hit(ex_q, use_rs1, rs1))       fwd_rs1_d = 2'd1;
      else if (hit(mem_q, use_rs1, rs1)) fwd_rs1_d = 2'd2;
      if (hit(ex_q, use_rs2, rs2))       fwd_rs2_d = 2'd1;
      else if (hit(mem_q, use_rs2, rs2)) fwd_rs2_d = 2'd2;
    end
  end

  // Sequencer state; a frozen pipeline keeps its state.
  always_ff @(posedge clk) begin
    if (rst)          state_q <= S_RUN;
    else if (!freeze) state_q <= state_d;
  end

  // Scoreboard shift and forwarding registers advance together with the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_rs1_q <= 2'd0;
      fwd_rs2_q <= 2'd0;
    end else if (!freeze) begin
      ex_q      <= bubble_ex ? '0 : id_slot;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      fwd_rs1_q <= fwd_rs1_d;
      fwd_rs2_q <= fwd_rs2_d;
    end
  end

  // Stall-cycle performance counter, free-running modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst)           cnt_q <= '0;
    else if (stall_pc) cnt_q <= cnt_q + 1'b1;
  end

  assign fwd_rs1      = fwd_rs1_q;
  assign fwd_rs2      = fwd_rs2_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with a behavioural pipeline model
module tb_hazard_ctrl;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] LW_X5    = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD_X5   = 32'h0072_8333; // add  x6,x5,x7
  localparam logic [31:0] LW_X0    = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X0   = 32'h0070_0333; // add  x6,x0,x7
  localparam logic [31:0] ADDI_X3  = 32'h0010_0193; // addi x3,x0,1
  localparam logic [31:0] SUB_X4   = 32'h4031_8233; // sub  x4,x3,x3
  localparam logic [31:0] OR_X8    = 32'h0031_6433; // or   x8,x2,x3
  localparam logic [31:0] ADDI_X10 = 32'h0050_0513; // addi x10,x0,5
  localparam logic [31:0] ADDI_X11 = 32'h0050_0593; // addi x11,x0,5
  localparam logic [31:0] ADDI_X12 = 32'h0050_0613; // addi x12,x0,5
  localparam logic [31:0] CSRW     = 32'h51E0_9073; // csrw 0x51e,x1

  logic        clk = 1'b0;
  logic        rst, id_valid, ex_redirect, mem_busy;
  logic [31:0] id_inst;
  logic        stall_pc, stall_if_id, flush_if_id, bubble_ex, freeze;
  logic [1:0]  fwd_rs1, fwd_rs2;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .bubble_ex(bubble_ex), .freeze(freeze), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .stall_cycles(stall_cycles)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] prog[$];

  // Model: in-flight instructions by stage (0=EX, 1=MEM, 2=WB), redirect-refill flag, fwd, counter.
  bit          m_v[3] = '{default: 1'b0};
  logic [31:0] m_i[3] = '{default: 32'h0};
  bit          m_redir = 1'b0;
  logic [1:0]  m_f1 = 2'd0, m_f2 = 2'd0;
  logic [31:0] m_cnt = 32'd0;

  function automatic logic [4:0] f_rd(input logic [31:0] i);  return i[11:7];  endfunction
  function automatic logic [4:0] f_rs1(input logic [31:0] i); return i[19:15]; endfunction
  function automatic logic [4:0] f_rs2(input logic [31:0] i); return i[24:20]; endfunction
  function automatic bit f_load(input logic [31:0] i); return i[6:0] == 7'h03; endfunction
  function automatic bit f_csr(input logic [31:0] i);
    return (i[6:0] == 7'h73) && (i[14:12] != 3'd0);
  endfunction
  function automatic bit f_writes(input logic [31:0] i);
    return (f_rd(i) != 5'd0) &&
           ((i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h6f, 7'h67, 7'h37, 7'h17}) || f_csr(i));
  endfunction
  function automatic bit f_use1(input logic [31:0] i);
    return (i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67}) || (f_csr(i) && !i[14]);
  endfunction
  function automatic bit f_use2(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  // Newest producer wins: EX stage result (1) over MEM stage (2).
  function automatic logic [1:0] fwd_of(input bit used, input logic [4:0] r);
    logic [1:0] res = 2'd0;
    if (used && r != 5'd0) begin
      if (m_v[1] && f_writes(m_i[1]) && f_rd(m_i[1]) == r) res = 2'd2;
      if (m_v[0] && f_writes(m_i[0]) && f_rd(m_i[0]) == r) res = 2'd1;
    end
    return res;
  endfunction

  // Expected {stall_pc, stall_if_id, flush_if_id, bubble_ex, freeze}.
  function automatic logic [4:0] exp_ctl();
    bit lu, cw;
    if (rst)         return 5'b00110;
    if (mem_busy)    return 5'b11001;
    if (ex_redirect) return 5'b00110;
    if (m_redir)     return 5'b00100;
    lu = id_valid && m_v[0] && f_load(m_i[0]) && f_writes(m_i[0]) &&
         ((f_use1(id_inst) && f_rs1(id_inst) == f_rd(m_i[0])) ||
          (f_use2(id_inst) && f_rs2(id_inst) == f_rd(m_i[0])));
    cw = id_valid && f_csr(id_inst) && (m_v[0] || m_v[1] || m_v[2]);
    return (lu || cw) ? 5'b11010 : 5'b00000;
  endfunction

  task automatic model_update(input logic [4:0] e);
    if (rst) begin
      m_v     = '{default: 1'b0};
      m_redir = 1'b0;
      m_f1    = 2'd0;
      m_f2    = 2'd0;
      m_cnt   = 32'd0;
    end else begin
      if (e[4]) m_cnt = m_cnt + 32'd1;
      if (!mem_busy) begin
        if (e[1] || !id_valid) begin
          m_f1 = 2'd0;
          m_f2 = 2'd0;
        end else begin
          m_f1 = fwd_of(f_use1(id_inst), f_rs1(id_inst));
          m_f2 = fwd_of(f_use2(id_inst), f_rs2(id_inst));
        end
        m_v[2] = m_v[1]; m_i[2] = m_i[1];
        m_v[1] = m_v[0]; m_i[1] = m_i[0];
        m_v[0] = id_valid && !e[1];
        m_i[0] = id_inst;
        m_redir = ex_redirect;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model, then act as fetch (flush -> bubble, hold -> keep, else next).
  task automatic cyc(input logic r, input logic red, input logic busy);
    logic [4:0] e;
    @(posedge clk);
    e = exp_ctl();
    model_update(e);
    #1;
    if (e[2]) begin
      id_valid = 1'b0;
      id_inst  = NOP;
    end else if (!e[3]) begin
      if (prog.size() > 0) begin
        id_inst  = prog.pop_front();
        id_valid = 1'b1;
      end else begin
        id_valid = 1'b0;
        id_inst  = NOP;
      end
    end
    rst         = r;
    ex_redirect = red;
    mem_busy    = busy;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // Every-cycle comparison of the DUT against the model.
  logic [4:0] ce;
  initial begin
    forever begin
      @(negedge clk);
      ce = exp_ctl();
      check("m_stall_pc",    32'(stall_pc),    32'(ce[4]));
      check("m_stall_if_id", 32'(stall_if_id), 32'(ce[3]));
      check("m_flush_if_id", 32'(flush_if_id), 32'(ce[2]));
      check("m_bubble_ex",   32'(bubble_ex),   32'(ce[1]));
      check("m_freeze",      32'(freeze),      32'(ce[0]));
      check("m_fwd_rs1",     32'(fwd_rs1),     32'(m_f1));
      check("m_fwd_rs2",     32'(fwd_rs2),     32'(m_f2));
      check("m_stall_cycles", stall_cycles,    m_cnt);
      check("m_hold_and_flush", 32'(stall_if_id & flush_if_id), 32'd0);
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_inst = NOP; ex_redirect = 1'b0; mem_busy = 1'b0;
    #2;
    check("rst_bubble", 32'(bubble_ex), 32'd1);
    check("rst_flush",  32'(flush_if_id), 32'd1);
    check("rst_stall",  32'(stall_pc), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    check("rst2_bubble", 32'(bubble_ex), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_cnt",  stall_cycles, 32'd0);
    check("rst_fwd1", 32'(fwd_rs1), 32'd0);
    check("rst_fwd2", 32'(fwd_rs2), 32'd0);

    // Load-use.
    prog.push_back(LW_X5); prog.push_back(ADD_X5);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("lu_stall_pc", 32'(stall_pc), 32'd1);
    check("lu_bubble",   32'(bubble_ex), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("lu_release", 32'(stall_pc), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("lu_fwd1", 32'(fwd_rs1), 32'd2);
    check("lu_fwd2", 32'(fwd_rs2), 32'd0);
    check("lu_cnt",  stall_cycles, 32'd1);
    idle(3);

    // Load to x0 never stalls.
    prog.push_back(LW_X0); prog.push_back(ADD_X0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("x0_no_stall", 32'(stall_pc), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("x0_fwd1", 32'(fwd_rs1), 32'd0);
    check("x0_cnt",  stall_cycles, 32'd1);
    idle(3);

    // ALU forwarding.
    prog.push_back(ADDI_X3); prog.push_back(SUB_X4); prog.push_back(OR_X8);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("alu_no_stall", 32'(stall_pc), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("sub_fwd1", 32'(fwd_rs1), 32'd1);
    check("sub_fwd2", 32'(fwd_rs2), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("or_fwd1", 32'(fwd_rs1), 32'd0);
    check("or_fwd2", 32'(fwd_rs2), 32'd2);
    idle(3);

    // Redirect; the target CSR sees an empty pipeline only if the killed slots never entered EX.
    prog.push_back(ADDI_X10); prog.push_back(ADDI_X11);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    prog.push_back(CSRW);
    check("rd_flush",  32'(flush_if_id), 32'd1);
    check("rd_bubble", 32'(bubble_ex), 32'd1);
    check("rd_hold",   32'(stall_if_id), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("redir_flush",  32'(flush_if_id), 32'd1);
    check("redir_pc",     32'(stall_pc), 32'd0);
    check("redir_bubble", 32'(bubble_ex), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("redir_run", 32'(flush_if_id), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("redir_killed", 32'(stall_pc), 32'd0);
    idle(3);

    // CSR drain behind three ALU ops.
    prog.push_back(ADDI_X10); prog.push_back(ADDI_X11); prog.push_back(ADDI_X12); prog.push_back(CSRW);
    idle(3);
    cyc(1'b0, 1'b0, 1'b0);
    check("drain1", 32'(stall_pc), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("drain2", 32'(stall_pc), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("drain3", 32'(stall_pc), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("drain_issue", 32'(stall_pc), 32'd0);
    check("drain_cnt",   stall_cycles, 32'd4);
    idle(3);

    // Redirect during the 2nd drain cycle drops the CSR.
    prog.push_back(ADDI_X10); prog.push_back(ADDI_X11); prog.push_back(ADDI_X12); prog.push_back(CSRW);
    idle(3);
    cyc(1'b0, 1'b0, 1'b0);
    check("drd1", 32'(stall_pc), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    check("drd_flush", 32'(flush_if_id), 32'd1);
    check("drd_hold",  32'(stall_if_id), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("drd_redir", 32'(flush_if_id), 32'd1);
    check("drd_cnt",   stall_cycles, 32'd5);
    cyc(1'b0, 1'b0, 1'b0);
    check("drd_run", 32'(stall_pc), 32'd0);
    idle(3);

    // Memory wait over a load-use stall.
    prog.push_back(LW_X5); prog.push_back(ADD_X5);
    cyc(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b1);
      check("mw_freeze", 32'(freeze), 32'd1);
      check("mw_bubble", 32'(bubble_ex), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check("mw_lu_stall", 32'(stall_pc), 32'd1);
    check("mw_unfreeze", 32'(freeze), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("mw_release", 32'(stall_pc), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("mw_fwd1", 32'(fwd_rs1), 32'd2);
    check("mw_cnt",  stall_cycles, 32'd10);
    idle(3);

    // Reset in the middle of a drain.
    prog.push_back(ADDI_X10); prog.push_back(ADDI_X11); prog.push_back(ADDI_X12); prog.push_back(CSRW);
    idle(3);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("rd_mid_drain", 32'(stall_pc), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    check("rdr_stall", 32'(stall_pc), 32'd0);
    check("rdr_flush", 32'(flush_if_id), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("rdr_no_residual", 32'(stall_pc), 32'd0);
    check("rdr_cnt",         stall_cycles, 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
